// File: rtl/const_stream_gen_if.sv
// Output sample stream: registered data/valid from the generator, ready from downstream.
// Latency: n/a (wiring only).
// Backpressure: the generator holds data/valid while valid && !ready.
interface const_stream_gen_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/const_stream_gen.sv
// Sample source: constant, wrapping ramp, saturating ramp or cyclic table on a valid/ready stream.
// Latency: 1 clk from en to the first valid sample; one new sample per accepted handshake.
// Backpressure: valid && !ready freezes out_data/out_valid unconditionally; loads are deferred to the next advance.
module const_stream_gen #(
  parameter int                       WIDTH = 32,
  parameter logic signed [WIDTH-1:0]  INIT  = '0,
  parameter int                       DEPTH = 8,
  parameter int                       AW    = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_en,
  input  logic [1:0]               i_mode,
  input  logic signed [WIDTH-1:0]  i_step,
  input  logic                     i_load,
  input  logic signed [WIDTH-1:0]  i_load_val,
  input  logic                     i_tbl_we,
  input  logic [AW-1:0]            i_tbl_addr,
  input  logic [WIDTH-1:0]         i_tbl_wdata,
  const_stream_gen_if.master       o_strm
);

  localparam logic [1:0] M_CONST = 2'd0;
  localparam logic [1:0] M_WRAP  = 2'd1;
  localparam logic [1:0] M_SAT   = 2'd2;
  localparam logic [1:0] M_TABLE = 2'd3;

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [WIDTH-1:0]   r_acc;
  logic [AW-1:0]             r_ptr;
  logic                      r_pend;     // a load arrived during a stall; next advance presents it as-is
  logic [WIDTH-1:0]          r_out_data;
  logic [WIDTH-1:0]          r_tbl [DEPTH];

  logic signed [WIDTH-1:0]   w_acc_nxt;
  logic [AW-1:0]             w_ptr_nxt;
  logic                      w_pend_nxt;
  logic [WIDTH-1:0]          w_out_nxt;
  logic                      w_fire;
  logic                      w_start;
  logic                      w_take;
  logic [WIDTH:0]            w_sum_ext;
  logic signed [WIDTH-1:0]   w_sum_sat;
  logic [AW-1:0]             w_ptr_inc;
  logic                      w_addr_ok;

  assign w_fire    = (r_state == ST_RUN) && o_strm.out_ready;
  assign w_start   = (r_state == ST_IDLE) && i_en;
  assign w_take    = w_fire || w_start;
  assign w_sum_ext = {r_acc[WIDTH-1], r_acc} + {i_step[WIDTH-1], i_step};
  assign w_sum_sat = (w_sum_ext[WIDTH] != w_sum_ext[WIDTH-1])
                     ? (w_sum_ext[WIDTH] ? SMIN : SMAX)
                     : w_sum_ext[WIDTH-1:0];
  assign w_ptr_inc = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign w_addr_ok = int'(i_tbl_addr) < DEPTH;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: start on en, leave RUN only when the last sample is accepted with en low
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_en) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_fire && !i_en) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs come straight from registers
  always_comb begin
    o_strm.out_valid = (r_state == ST_RUN);
    o_strm.out_data  = r_out_data;
  end

  // Next sample, accumulator and table pointer; load overrides the mode's advance
  always_comb begin
    w_acc_nxt  = r_acc;
    w_ptr_nxt  = r_ptr;
    w_pend_nxt = r_pend;
    w_out_nxt  = r_out_data;
    if (i_load) begin
      w_acc_nxt = i_load_val;
      w_ptr_nxt = '0;
      if (w_take) begin
        w_out_nxt  = (i_mode == M_TABLE) ? r_tbl[0] : i_load_val;
        w_pend_nxt = 1'b0;
      end else if (r_state == ST_RUN) begin
        w_pend_nxt = 1'b1;
      end
    end else if (w_take) begin
      w_pend_nxt = 1'b0;
      if (w_start || r_pend) begin
        w_out_nxt = (i_mode == M_TABLE) ? r_tbl[r_ptr] : r_acc;
      end else begin
        case (i_mode)
          M_CONST: w_out_nxt = r_acc;
          M_WRAP: begin
            w_acc_nxt = w_sum_ext[WIDTH-1:0];
            w_out_nxt = w_sum_ext[WIDTH-1:0];
          end
          M_SAT: begin
            w_acc_nxt = w_sum_sat;
            w_out_nxt = w_sum_sat;
          end
          default: begin
            w_ptr_nxt = w_ptr_inc;
            w_out_nxt = r_tbl[w_ptr_inc];
          end
        endcase
      end
    end
  end

  // Datapath registers and table; reads above see pre-write table contents
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc      <= INIT;
      r_ptr      <= '0;
      r_pend     <= 1'b0;
      r_out_data <= INIT;
      for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_ptr      <= w_ptr_nxt;
      r_pend     <= w_pend_nxt;
      r_out_data <= w_out_nxt;
      if (i_tbl_we && w_addr_ok) r_tbl[i_tbl_addr] <= i_tbl_wdata;
    end
  end

endmodule

// File: tb/tb_const_stream_gen.sv
// Randomized and directed bench for const_stream_gen with a queue-based scoreboard.
module tb_const_stream_gen;
  localparam int W     = 32;
  localparam int DEPTH = 5;
  localparam int AW    = 3;
  localparam logic signed [W-1:0] INIT = 32'sd5;
  localparam longint MAXV  = 64'sd2147483647;
  localparam longint MINV  = -64'sd2147483648;
  localparam longint TWO32 = 64'sd4294967296;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                en = 1'b0;
  logic [1:0]          mode = 2'd0;
  logic signed [W-1:0] step = '0;
  logic                load = 1'b0;
  logic signed [W-1:0] load_val = '0;
  logic                tbl_we = 1'b0;
  logic [AW-1:0]       tbl_addr = '0;
  logic [W-1:0]        tbl_wdata = '0;

  const_stream_gen_if #(.WIDTH(W)) strm ();

  const_stream_gen #(.WIDTH(W), .INIT(INIT), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .i_en(en), .i_mode(mode), .i_step(step),
    .i_load(load), .i_load_val(load_val), .i_tbl_we(tbl_we), .i_tbl_addr(tbl_addr),
    .i_tbl_wdata(tbl_wdata), .o_strm(strm)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_run = 1'b0;
  longint      m_acc = 0;
  int          m_ptr = 0;
  bit          m_fresh = 1'b0;
  logic [W-1:0] m_tbl [DEPTH];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] seen [$];

  // Behavioural rules applied to the inputs present at a rising edge
  task automatic model_step();
    logic [W-1:0] val;
    bit fire, start, take;
    longint s;
    val = '0;
    if (!reset_n) begin
      m_run = 1'b0; m_acc = longint'(INIT); m_ptr = 0; m_fresh = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
      return;
    end
    fire  = m_run && strm.out_ready;
    start = !m_run && en;
    take  = fire || start;
    if (load) begin
      m_acc = longint'(load_val);
      m_ptr = 0;
      if (take) val = (mode == 2'd3) ? m_tbl[0] : load_val;
      else if (m_run) m_fresh = 1'b1;
    end else if (take) begin
      if (start || m_fresh) begin
        val = (mode == 2'd3) ? m_tbl[m_ptr] : W'(m_acc);
      end else begin
        case (mode)
          2'd0: val = W'(m_acc);
          2'd1: begin
            s = (m_acc + longint'(step)) % TWO32;
            if (s < 0) s += TWO32;
            if (s > MAXV) s -= TWO32;
            m_acc = s; val = W'(s);
          end
          2'd2: begin
            s = m_acc + longint'(step);
            if (s > MAXV) s = MAXV;
            if (s < MINV) s = MINV;
            m_acc = s; val = W'(s);
          end
          default: begin
            m_ptr = (m_ptr + 1) % DEPTH;
            val = m_tbl[m_ptr];
          end
        endcase
      end
    end
    if (take) m_fresh = 1'b0;
    if (tbl_we && int'(tbl_addr) < DEPTH) m_tbl[tbl_addr] = tbl_wdata;
    if (start) m_run = 1'b1;
    else if (fire && !en) m_run = 1'b0;
    if (take && m_run) exp_q.push_back(val);
  endtask

  // Monitor: valid vs model every cycle; new samples popped from the scoreboard, held samples must not move
  bit           prev_valid = 1'b0;
  bit           prev_fire = 1'b0;
  logic [W-1:0] held = '0;
  logic [W-1:0] e;
  always @(negedge clk) begin
    checks++;
    if (strm.out_valid !== m_run) begin
      errors++;
      $display("FAIL valid: got %b want %b at %0t", strm.out_valid, m_run, $time);
    end
    if (strm.out_valid === 1'b1) begin
      if (!prev_valid || prev_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample: got %h want none (queue empty) at %0t", strm.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (strm.out_data !== e) begin
            errors++;
            $display("FAIL sample: got %h want %h at %0t", strm.out_data, e, $time);
          end
        end
        held = strm.out_data;
        seen.push_back(strm.out_data);
      end else begin
        checks++;
        if (strm.out_data !== held) begin
          errors++;
          $display("FAIL hold: got %h want %h at %0t", strm.out_data, held, $time);
        end
      end
    end
    prev_valid = (strm.out_valid === 1'b1);
    prev_fire  = (strm.out_valid === 1'b1) && strm.out_ready;
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    load = 1'b0;
    tbl_we = 1'b0;
  endtask

  task automatic check_now(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_seq(input string name, input logic [W-1:0] lit [$]);
    @(negedge clk);
    #1;
    checks++;
    if (seen.size() != lit.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d want %0d", name, seen.size(), lit.size());
    end else begin
      foreach (lit[i]) check_neq_free(name, seen[i], lit[i]);
    end
    seen.delete();
  endtask

  task automatic check_neq_free(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    check_now(name, act, exp);
  endtask

  // en high for n accepted-or-started samples, then one accepting cycle with en low
  task automatic run_n(input int n);
    en = 1'b1;
    repeat (n) tick();
    en = 1'b0;
    tick();
  endtask

  logic [W-1:0] lit [$];

  initial begin
    strm.out_ready = 1'b1;
    // 1: reset state, then CONST at INIT
    tick(); tick();
    reset_n = 1'b1;
    @(negedge clk); #1;
    check_now("rst_valid", W'(strm.out_valid), W'(0));
    check_now("rst_data", strm.out_data, 32'd5);
    seen.delete();
    en = 1'b1;
    tick();
    check_now("t1_valid_rise", W'(strm.out_valid), W'(1));
    repeat (3) tick();
    en = 1'b0;
    tick();
    lit = '{32'd5, 32'd5, 32'd5, 32'd5};
    check_seq("t1_const", lit);

    // 2: wrapping ramp across the positive limit
    mode = 2'd1; step = 32'sd1; load_val = 32'h7FFF_FFFE; load = 1'b1;
    tick();
    run_n(3);
    lit = '{32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};
    check_seq("t2_wrap", lit);

    // 3: saturating ramp at both limits
    mode = 2'd2; load_val = 32'h7FFF_FFFE; load = 1'b1;
    tick();
    run_n(3);
    lit = '{32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    check_seq("t3_sat_hi", lit);
    step = -32'sd3; load_val = 32'h8000_0001; load = 1'b1;
    tick();
    run_n(2);
    lit = '{32'h8000_0001, 32'h8000_0000};
    check_seq("t3_sat_lo", lit);

    // 4: table wraps at DEPTH-1; writes beyond DEPTH are ignored
    mode = 2'd3;
    for (int i = 0; i < 8; i++) begin
      tbl_we = 1'b1; tbl_addr = AW'(i);
      tbl_wdata = (i < DEPTH) ? W'((i + 1) * 10) : 32'd99;
      tick();
    end
    load = 1'b1; load_val = '0;
    tick();
    run_n(7);
    lit = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd10, 32'd20};
    check_seq("t4_table", lit);

    // 5: stall with mode/en changes, then one accept ends the stream
    mode = 2'd1; step = 32'sd2; load_val = 32'sd100; load = 1'b1;
    tick();
    en = 1'b1;
    tick(); tick();
    strm.out_ready = 1'b0; mode = 2'd0; en = 1'b0;
    repeat (3) tick();
    strm.out_ready = 1'b1;
    tick();
    @(negedge clk); #1;
    check_now("t5_valid_drop", W'(strm.out_valid), W'(0));
    lit = '{32'd100, 32'd102};
    check_seq("t5_stall", lit);

    // 6: reset during stall, stalled load, load on accept
    mode = 2'd1; step = 32'sd1; load_val = 32'sd1000; load = 1'b1;
    tick();
    en = 1'b1;
    tick();
    strm.out_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; en = 1'b0;
    @(negedge clk); #1;
    check_now("t6_rst_valid", W'(strm.out_valid), W'(0));
    check_now("t6_rst_data", strm.out_data, 32'd5);
    seen.delete();
    strm.out_ready = 1'b1; en = 1'b1;
    tick();
    strm.out_ready = 1'b0; load = 1'b1; load_val = 32'sd200;
    tick();
    strm.out_ready = 1'b1;
    tick();
    load = 1'b1; load_val = 32'sd300;
    tick();
    tick();
    en = 1'b0;
    tick();
    lit = '{32'd5, 32'd200, 32'd300, 32'd301};
    check_seq("t6_load", lit);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      en             = ($urandom % 8) != 0;
      strm.out_ready = ($urandom % 4) != 0;
      mode           = 2'($urandom % 4);
      case ($urandom % 4)
        0:       step = W'($urandom);
        1:       step = 32'sh7FFF_FFF0 + W'($urandom % 32);
        default: step = W'(int'($urandom % 17) - 8);
      endcase
      load     = ($urandom % 16) == 0;
      load_val = ($urandom % 2) ? W'($urandom) : (32'sh7FFF_FFF8 + W'($urandom % 16));
      tbl_we    = ($urandom % 4) == 0;
      tbl_addr  = AW'($urandom % 8);
      tbl_wdata = W'($urandom);
      reset_n   = ($urandom % 200) != 0;
      tick();
    end
    reset_n = 1'b1; en = 1'b0; strm.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
